// File: rtl/gray_code_counter_if.sv
// Bundle of the counter controls/status and the converter stream for gray_code_counter.
// The slave side is the counter block; the master side drives controls and observes results.
interface gray_code_counter_if #(
  parameter int N = 4
);
  logic         clr;
  logic         load;
  logic         load_gray;
  logic [N-1:0] load_val;
  logic         en;
  logic         up;
  logic [N-1:0] bin_out;
  logic [N-1:0] gray_out;
  logic         wrap;
  logic         cvt_valid_in;
  logic         cvt_mode;
  logic [N-1:0] cvt_din;
  logic         cvt_valid_out;
  logic [N-1:0] cvt_dout;

  modport master (
    output clr, load, load_gray, load_val, en, up,
    output cvt_valid_in, cvt_mode, cvt_din,
    input  bin_out, gray_out, wrap, cvt_valid_out, cvt_dout
  );

  modport slave (
    input  clr, load, load_gray, load_val, en, up,
    input  cvt_valid_in, cvt_mode, cvt_din,
    output bin_out, gray_out, wrap, cvt_valid_out, cvt_dout
  );
endinterface

// File: rtl/gray_code_counter.sv
// Up/down binary counter with a registered Gray shadow and wrap pulse, plus an
// independent one-cycle binary<->Gray converter pipe.
module gray_code_counter #(
  parameter int N = 4
) (
  input logic               clk,
  input logic               rst_n,
  gray_code_counter_if.slave bus
);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [N-1:0] bin_q, gray_q, bin_nxt;
  logic         wrap_q, wrap_nxt;
  logic         cvt_valid_q;
  logic [N-1:0] cvt_dout_q;

  // Priority clr > load > en; wrap only comes from a real counting step.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    if (bus.clr) begin
      bin_nxt = '0;
    end else if (bus.load) begin
      bin_nxt = bus.load_gray ? gray2bin(bus.load_val) : bus.load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        bin_nxt  = bin_q + ONE;
        wrap_nxt = &bin_q;
      end else begin
        bin_nxt  = bin_q - ONE;
        wrap_nxt = ~|bin_q;
      end
    end
  end

  // Gray is registered from the same next value, so it never glitches off bin_q.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= bin2gray(bin_nxt);
      wrap_q <= wrap_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cvt_valid_q <= 1'b0;
      cvt_dout_q  <= '0;
    end else begin
      cvt_valid_q <= bus.cvt_valid_in;
      if (bus.cvt_valid_in) begin
        cvt_dout_q <= bus.cvt_mode ? gray2bin(bus.cvt_din) : bin2gray(bus.cvt_din);
      end
    end
  end

  assign bus.bin_out       = bin_q;
  assign bus.gray_out      = gray_q;
  assign bus.wrap          = wrap_q;
  assign bus.cvt_valid_out = cvt_valid_q;
  assign bus.cvt_dout      = cvt_dout_q;
endmodule

// File: tb/tb_gray_code_counter.sv
// Self-checking bench: an integer-arithmetic model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_gray_code_counter;
  localparam int N   = 4;
  localparam int MOD = 1 << N;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_on = 1'b0;

  gray_code_counter_if #(.N(N)) bus ();

  gray_code_counter #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counter is an integer mod 2^N; Gray is b^(b>>1); decode by search.
  function automatic int m_enc(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int m_dec(input int g);
    for (int b = 0; b < MOD; b++) begin
      if (m_enc(b) == g) return b;
    end
    return -1;
  endfunction

  int m_bin = 0, m_wrap = 0, m_cv = 0, m_cd = 0;
  bit m_step = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_bin = 0; m_wrap = 0; m_cv = 0; m_cd = 0; m_step = 1'b0;
    end else begin
      m_step = 1'b0;
      m_wrap = 0;
      if (bus.clr) begin
        m_bin = 0;
      end else if (bus.load) begin
        m_bin = bus.load_gray ? m_dec(int'(bus.load_val)) : int'(bus.load_val);
      end else if (bus.en) begin
        m_step = 1'b1;
        if (bus.up) begin
          m_wrap = (m_bin == MOD - 1) ? 1 : 0;
          m_bin  = (m_bin + 1) % MOD;
        end else begin
          m_wrap = (m_bin == 0) ? 1 : 0;
          m_bin  = (m_bin + MOD - 1) % MOD;
        end
      end
      m_cv = int'(bus.cvt_valid_in);
      if (bus.cvt_valid_in)
        m_cd = bus.cvt_mode ? m_dec(int'(bus.cvt_din)) : m_enc(int'(bus.cvt_din));
    end
  end

  logic [N-1:0] prev_gray = '0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("bin_out",       32'(bus.bin_out),       32'(m_bin));
      check("gray_out",      32'(bus.gray_out),      32'(m_enc(m_bin)));
      check("wrap",          32'(bus.wrap),          32'(m_wrap));
      check("cvt_valid_out", 32'(bus.cvt_valid_out), 32'(m_cv));
      check("cvt_dout",      32'(bus.cvt_dout),      32'(m_cd));
      if (m_step)
        check("gray_one_bit_step", 32'($countones(bus.gray_out ^ prev_gray)), 32'd1);
    end
    prev_gray = bus.gray_out;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bin"},  32'(bus.bin_out),       32'd0);
    check({tag, "_gray"}, 32'(bus.gray_out),      32'd0);
    check({tag, "_wrap"}, 32'(bus.wrap),          32'd0);
    check({tag, "_cv"},   32'(bus.cvt_valid_out), 32'd0);
    check({tag, "_cd"},   32'(bus.cvt_dout),      32'd0);
  endtask

  initial begin
    bus.clr = 0; bus.load = 0; bus.load_gray = 0; bus.load_val = '0;
    bus.en = 0; bus.up = 1; bus.cvt_valid_in = 0; bus.cvt_mode = 0; bus.cvt_din = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset_async");
    tick(); tick();
    rst_n = 1'b1;
    chk_on = 1'b1;
    tick(); tick();
    check("idle_bin", 32'(bus.bin_out), 32'd0);

    // Up wrap from 1110.
    bus.load = 1; bus.load_val = 4'b1110;
    tick();
    bus.load = 0; bus.en = 1; bus.up = 1;
    check("load_bin", 32'(bus.bin_out), 32'b1110);
    tick();
    check("up1_bin",  32'(bus.bin_out),  32'b1111);
    check("up1_gray", 32'(bus.gray_out), 32'b1000);
    check("up1_wrap", 32'(bus.wrap),     32'd0);
    tick();
    bus.en = 0;
    check("upwrap_bin",  32'(bus.bin_out),  32'b0000);
    check("upwrap_gray", 32'(bus.gray_out), 32'b0000);
    check("upwrap_wrap", 32'(bus.wrap),     32'd1);
    tick();
    check("upwrap_pulse_end", 32'(bus.wrap), 32'd0);

    // Down wrap from 0, then 32 steps each way with per-step Gray checks.
    bus.en = 1; bus.up = 0;
    tick();
    check("dnwrap_bin",  32'(bus.bin_out),  32'b1111);
    check("dnwrap_gray", 32'(bus.gray_out), 32'b1000);
    check("dnwrap_wrap", 32'(bus.wrap),     32'd1);
    repeat (31) tick();
    bus.up = 1;
    repeat (32) tick();
    bus.en = 0;
    tick();

    // Gray-coded load, load beating a wrapping step, and everything at once.
    bus.load = 1; bus.load_gray = 1; bus.load_val = 4'b1001;
    tick();
    check("gload_bin",  32'(bus.bin_out),  32'b1110);
    check("gload_gray", 32'(bus.gray_out), 32'b1001);
    bus.load_gray = 0; bus.load_val = 4'b1111;
    tick();
    bus.load_val = 4'b0101; bus.en = 1; bus.up = 1;
    tick();
    check("load_over_wrap_bin",  32'(bus.bin_out), 32'b0101);
    check("load_over_wrap_wrap", 32'(bus.wrap),    32'd0);
    bus.en = 0; bus.load_val = 4'b1111;
    tick();
    bus.clr = 1; bus.load_val = 4'b0011; bus.en = 1;
    tick();
    check("clr_all_bin",  32'(bus.bin_out),  32'd0);
    check("clr_all_gray", 32'(bus.gray_out), 32'd0);
    check("clr_all_wrap", 32'(bus.wrap),     32'd0);
    bus.clr = 0; bus.load = 0; bus.en = 0;

    // Converter back-to-back with a mode change, then hold.
    bus.cvt_valid_in = 1; bus.cvt_mode = 0; bus.cvt_din = 4'b0101;
    tick();
    check("cvt_b2g_v", 32'(bus.cvt_valid_out), 32'd1);
    check("cvt_b2g_d", 32'(bus.cvt_dout),      32'b0111);
    bus.cvt_mode = 1; bus.cvt_din = 4'b1001;
    tick();
    check("cvt_g2b_d", 32'(bus.cvt_dout), 32'b1110);
    bus.cvt_valid_in = 0; bus.cvt_din = 4'b0000;
    tick();
    check("cvt_hold_v", 32'(bus.cvt_valid_out), 32'd0);
    check("cvt_hold_d", 32'(bus.cvt_dout),      32'b1110);

    // Reset in the middle of a count and a converter stream.
    bus.en = 1; bus.up = 1; bus.cvt_valid_in = 1;
    for (int i = 0; i < 6; i++) begin
      bus.cvt_mode = i[0];
      bus.cvt_din  = 4'(3 * i + 1);
      tick();
    end
    rst_n = 1'b0;
    #1 check_all_zero("reset_mid");
    bus.cvt_valid_in = 0;
    tick();
    rst_n = 1'b1;
    tick();
    check("restart_bin", 32'(bus.bin_out),       32'd1);
    check("restart_cv",  32'(bus.cvt_valid_out), 32'd0);
    bus.cvt_valid_in = 1; bus.cvt_mode = 0; bus.cvt_din = 4'b1000;
    tick();
    check("restart_cv_new", 32'(bus.cvt_valid_out), 32'd1);
    check("restart_cd_new", 32'(bus.cvt_dout),      32'b1100);
    bus.cvt_valid_in = 0; bus.en = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gray_code_counter.md
GRAY_CODE_COUNTER -- requirements
Module: gray_code_counter

Interface
REQ-001 Parameter: N, default 4, counter and converter width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: clr  input  1  synchronous clear of the counter.
REQ-005 Port: load  input  1  synchronous load of the counter from load_val.
REQ-006 Port: load_gray  input  1  0 = load_val is binary, 1 = load_val is Gray code.
REQ-007 Port: load_val  input  N  load value.
REQ-008 Port: en  input  1  count enable.
REQ-009 Port: up  input  1  1 = increment, 0 = decrement.
REQ-010 Port: bin_out  output  N  registered counter value, binary.
REQ-011 Port: gray_out  output  N  registered counter value, Gray code.
REQ-012 Port: wrap  output  1  registered one-cycle pulse on counter wrap.
REQ-013 Port: cvt_valid_in  input  1  converter input qualifier.
REQ-014 Port: cvt_mode  input  1  0 = binary-to-Gray, 1 = Gray-to-binary.
REQ-015 Port: cvt_din  input  N  converter input word.
REQ-016 Port: cvt_valid_out  output  1  converter output qualifier.
REQ-017 Port: cvt_dout  output  N  converter result.

Function
REQ-018 Gray encoding SHALL be g[N-1]=b[N-1], g[i]=b[i+1]^b[i] for i<N-1.
REQ-019 Gray decoding SHALL be b[N-1]=g[N-1], b[i]=b[i+1]^g[i] for i<N-1.
REQ-020 Counter priority per cycle SHALL be clr > load > en; with none asserted, the counter holds.
REQ-021 clr SHALL set bin_out and gray_out to 0 on the next edge; wrap SHALL be 0 that cycle.
REQ-022 load with load_gray=0 SHALL set bin_out=load_val; with load_gray=1 it SHALL set bin_out=decode(load_val); in both cases wrap=0.
REQ-023 en with up=1 SHALL set bin_out=bin_out+1 modulo 2^N; en with up=0 SHALL set bin_out=bin_out-1 modulo 2^N.
REQ-024 gray_out SHALL equal encode(bin_out) on every cycle, both registered on the same edge; it is not derived combinationally from bin_out.
REQ-025 During counting, gray_out SHALL change in exactly one bit per enabled step, including across wrap.
REQ-026 wrap SHALL be 1 for exactly the one cycle following a step from all-ones to 0 (up) or from 0 to all-ones (down), and 0 otherwise.
REQ-027 Load or clr asserted in the same cycle as a wrapping step SHALL suppress both the step and the wrap pulse.
REQ-028 Holding en high with up=1 SHALL produce one wrap pulse every 2^N cycles.
REQ-029 Converter latency SHALL be exactly 1 cycle: cvt_valid_out on edge k+1 equals cvt_valid_in at edge k.
REQ-030 When cvt_valid_in=1, cvt_dout SHALL load encode(cvt_din) if cvt_mode=0 and decode(cvt_din) if cvt_mode=1.
REQ-031 When cvt_valid_in=0, cvt_dout SHALL hold its last value.
REQ-032 Back-to-back valid inputs SHALL be accepted every cycle with no stall; cvt_mode is sampled per word.
REQ-033 The converter SHALL be fully independent of counter state and controls.

Reset
REQ-034 While rst_n=0, bin_out, gray_out, wrap, cvt_valid_out and cvt_dout SHALL all be 0, asynchronously and without waiting for clk.
REQ-035 Reset asserted mid-count or mid-conversion SHALL discard in-flight state; the first edge after deassertion SHALL act on the inputs of that cycle only.

Verification (N=4)
REQ-036 Reset: assert rst_n=0 between edges -> all outputs 0 immediately; release, en=0 -> outputs hold 0.
REQ-037 Up wrap: load 4'b1110, then en=1, up=1 for 2 cycles -> bin 1111/gray 1000, then bin 0000/gray 0000 with wrap=1 for one cycle only.
REQ-038 Down wrap: from 0, en=1, up=0 -> bin 1111, gray 1000, wrap=1 for one cycle; checker confirms single-bit Gray change over 32 consecutive steps in each direction.
REQ-039 Gray load: load=1, load_gray=1, load_val=4'b1001 -> bin_out 1110, gray_out 1001; clr, load and en all asserted together -> bin 0000, wrap 0.
REQ-040 Converter: mode 0, din 0101 -> dout 0111 one cycle later; next cycle mode 1, din 1001 -> dout 1110; then valid low -> valid_out 0, dout holds 1110.
REQ-041 Reset mid-operation: assert rst_n during a continuous count and a converter stream -> outputs 0 immediately; after release, count restarts from 0 and valid_out stays 0 until new input.
